// File: rtl/data_memory_mmio.sv
// MEM-stage data RAM with memory-mapped timer, systick, LED, tube and UART registers.
// Define UART_TX_EN to build the serial transmitter; otherwise uart_txd idles high.
module data_memory_mmio #(
  parameter int RAM_WORDS  = 512,
  parameter int RAM_ADDR_W = 9,
  parameter int BAUD_DIV   = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  byte_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [3:0]  tube_display,
  output logic [7:0]  tube_segment,
  output logic [7:0]  led,
  output logic        irq,
  output logic        uart_txd
);
  localparam logic [31:0] MMIO_BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH      = 32'h4000_0000;
  localparam logic [31:0] A_TL      = 32'h4000_0004;
  localparam logic [31:0] A_TCON    = 32'h4000_0008;
  localparam logic [31:0] A_LED     = 32'h4000_000C;
  localparam logic [31:0] A_TUBE    = 32'h4000_0010;
  localparam logic [31:0] A_SYSTICK = 32'h4000_0014;
  localparam logic [31:0] A_UTXD    = 32'h4000_0018;
  localparam logic [31:0] A_UCON    = 32'h4000_0020;

  logic [31:0]           ram_q [RAM_WORDS];
  logic [31:0]           ram_wdata_d;
  logic [31:0]           th_q, th_d, tl_q, tl_d, systick_q;
  logic [2:0]            tcon_q, tcon_d;
  logic [7:0]            led_q;
  logic [11:0]           tube_q;
  logic [31:0]           mmio_rdata, uart_rdata;
  logic [RAM_ADDR_W-1:0] word_idx;
  logic                  is_mmio, wr_ram, wr_th, wr_tl, wr_tcon;

  assign is_mmio  = (address >= MMIO_BASE);
  assign word_idx = address[RAM_ADDR_W+1:2];
  assign wr_ram   = mem_write & ~is_mmio;
  assign wr_th    = mem_write & (address == A_TH);
  assign wr_tl    = mem_write & (address == A_TL);
  assign wr_tcon  = mem_write & (address == A_TCON);

  always_comb begin
    ram_wdata_d = ram_q[word_idx];
    for (int b = 0; b < 4; b++)
      if (byte_en[b]) ram_wdata_d[8*b +: 8] = write_data[8*b +: 8];
  end

  for (genvar w = 0; w < RAM_WORDS; w++) begin : g_ram
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        ram_q[w] <= '0;
      else if (wr_ram && word_idx == RAM_ADDR_W'(w))
        ram_q[w] <= ram_wdata_d;
    end
  end

  // A TH/TL store suppresses the count step; an overflow set is applied after a TCON store so it is never lost.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (wr_tcon) begin
      tcon_d[1:0] = write_data[1:0];
      if (!write_data[2]) tcon_d[2] = 1'b0;
    end
    if (wr_th) th_d = write_data;
    if (wr_tl) tl_d = write_data;
    if (tcon_q[0] && !wr_th && !wr_tl) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        if (tcon_q[1]) tcon_d[2] = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      tube_q    <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      systick_q <= systick_q + 32'd1;
      if (mem_write && address == A_LED)  led_q  <= write_data[7:0];
      if (mem_write && address == A_TUBE) tube_q <= write_data[11:0];
    end
  end

  assign irq          = tcon_q[2] & tcon_q[1];
  assign led          = led_q;
  assign tube_display = tube_q[11:8];
  assign tube_segment = tube_q[7:0];

`ifdef UART_TX_EN
  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;

  uart_state_e      ustate_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       tx_byte_q, shift_q;
  logic             txd_q, done_q, baud_last, wr_utxd, wr_ucon;

  assign baud_last = (baud_cnt_q == CNT_LAST);
  assign wr_utxd   = mem_write & (address == A_UTXD);
  assign wr_ucon   = mem_write & (address == A_UCON);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ustate_q   <= U_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      tx_byte_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      if (wr_ucon && !write_data[1]) done_q <= 1'b0;
      if (ustate_q != U_IDLE) baud_cnt_q <= baud_last ? '0 : baud_cnt_q + 1'b1;
      case (ustate_q)
        U_IDLE: if (wr_utxd) begin
          tx_byte_q <= write_data[7:0];
          shift_q   <= write_data[7:0];
          txd_q     <= 1'b0;
          done_q    <= 1'b0;
          ustate_q  <= U_START;
        end
        U_START: if (baud_last) begin
          txd_q     <= shift_q[0];
          shift_q   <= {1'b0, shift_q[7:1]};
          bit_idx_q <= '0;
          ustate_q  <= U_DATA;
        end
        U_DATA: if (baud_last) begin
          if (bit_idx_q == 3'd7) begin
            txd_q    <= 1'b1;
            ustate_q <= U_STOP;
          end else begin
            txd_q     <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        U_STOP: if (baud_last) begin
          done_q   <= 1'b1;
          ustate_q <= U_IDLE;
        end
        default: ustate_q <= U_IDLE;
      endcase
    end
  end

  assign uart_txd = txd_q;

  always_comb begin
    uart_rdata = '0;
    if (address == A_UTXD) uart_rdata = {24'd0, tx_byte_q};
    if (address == A_UCON) uart_rdata = {30'd0, done_q, ustate_q != U_IDLE};
  end
`else
  // BAUD_DIV only matters when the transmitter is built in.
  logic unused_baud_cfg;
  assign unused_baud_cfg = ^BAUD_DIV;
  assign uart_txd        = 1'b1;
  assign uart_rdata      = '0;
`endif

  always_comb begin
    case (address)
      A_TH:      mmio_rdata = th_q;
      A_TL:      mmio_rdata = tl_q;
      A_TCON:    mmio_rdata = {29'd0, tcon_q};
      A_LED:     mmio_rdata = {24'd0, led_q};
      A_TUBE:    mmio_rdata = {20'd0, tube_q};
      A_SYSTICK: mmio_rdata = systick_q;
      default:   mmio_rdata = uart_rdata;
    endcase
  end

  always_comb begin
    read_data = '0;
    if (mem_read) read_data = is_mmio ? mmio_rdata : ram_q[word_idx];
  end
endmodule

// File: tb/tb_data_memory_mmio.sv
// Randomized bench for data_memory_mmio against a behavioural map/timer/UART model.
// UART checks follow the UART_TX_EN build of the design.
module tb_data_memory_mmio;
  localparam int BAUD = 4;
  localparam logic [31:0] A_TH   = 32'h4000_0000, A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008, A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_TUBE = 32'h4000_0010, A_SYST = 32'h4000_0014;
  localparam logic [31:0] A_UTXD = 32'h4000_0018, A_UCON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset, mem_read, mem_write, irq, uart_txd;
  logic [3:0]  byte_en, tube_display;
  logic [31:0] address, write_data, read_data;
  logic [7:0]  tube_segment, led;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [31:0] m_mem [512];
  logic [31:0] m_th, m_tl, m_systick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led, m_ubyte;
  logic [11:0] m_tube;
  logic        m_done;
  bit          uq[$];

  logic [31:0] mmio_list [11] = '{A_TH, A_TL, A_TCON, A_LED, A_TUBE, A_SYST, A_UTXD, A_UCON,
                                  32'h4000_001C, 32'h4000_0024, 32'hFFFF_FFFC};

  data_memory_mmio #(.RAM_WORDS(512), .RAM_ADDR_W(9), .BAUD_DIV(BAUD)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .byte_en(byte_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .tube_display(tube_display), .tube_segment(tube_segment), .led(led), .irq(irq),
    .uart_txd(uart_txd));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = '0;
    m_th = '0; m_tl = '0; m_systick = '0; m_tcon = '0; m_led = '0; m_tube = '0;
    m_ubyte = '0; m_done = 1'b0;
    uq.delete();
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    bit busy = (uq.size() != 0);
    if (a < 32'h4000_0000) return m_mem[int'((a >> 2) % 32'd512)];
    case (a)
      A_TH:   return m_th;
      A_TL:   return m_tl;
      A_TCON: return {29'd0, m_tcon};
      A_LED:  return {24'd0, m_led};
      A_TUBE: return {20'd0, m_tube};
      A_SYST: return m_systick;
`ifdef UART_TX_EN
      A_UTXD: return {24'd0, m_ubyte};
      A_UCON: return {30'd0, m_done, busy};
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_txd();
`ifdef UART_TX_EN
    if (uq.size() != 0) return uq[0];
`endif
    return 1'b1;
  endfunction

  task automatic model_step();
    logic [31:0] tl0 = m_tl;
    logic [31:0] th0 = m_th;
    logic [2:0]  tc0 = m_tcon;
    bit          tw  = mem_write && (address == A_TH || address == A_TL);
    if (mem_write && address < 32'h4000_0000) begin
      for (int b = 0; b < 4; b++)
        if (byte_en[b]) m_mem[int'((address >> 2) % 32'd512)][8*b +: 8] = write_data[8*b +: 8];
    end else if (mem_write) begin
      case (address)
        A_TH:   m_th = write_data;
        A_TL:   m_tl = write_data;
        A_TCON: begin
          m_tcon[1:0] = write_data[1:0];
          if (!write_data[2]) m_tcon[2] = 1'b0;
        end
        A_LED:  m_led = write_data[7:0];
        A_TUBE: m_tube = write_data[11:0];
        default: ;
      endcase
    end
    if (tc0[0] && !tw) begin
      if (tl0 == 32'hFFFF_FFFF) begin
        m_tl = th0;
        if (tc0[1]) m_tcon[2] = 1'b1;
      end else m_tl = tl0 + 32'd1;
    end
    m_systick = m_systick + 32'd1;
`ifdef UART_TX_EN
    begin
      bit busy0 = (uq.size() != 0);
      bit fin = 1'b0;
      if (busy0) begin
        void'(uq.pop_front());
        fin = (uq.size() == 0);
      end
      if (mem_write && address == A_UCON && !write_data[1]) m_done = 1'b0;
      if (fin) m_done = 1'b1;
      if (mem_write && address == A_UTXD && !busy0) begin
        m_ubyte = write_data[7:0];
        m_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
          bit v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : write_data[k-1];
          repeat (BAUD) uq.push_back(v);
        end
      end
    end
`endif
  endtask

  task automatic set_bus(input logic rd, input logic wr, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; byte_en = be; address = a; write_data = wd;
  endtask

  // Check every output at the falling edge, then advance the model with the rising edge.
  task automatic tick();
    @(negedge clk);
    check_eq("read_data", read_data, mem_read ? model_read(address) : 32'd0);
    check_eq("led", 32'(led), 32'(m_led));
    check_eq("tube_display", 32'(tube_display), 32'(m_tube[11:8]));
    check_eq("tube_segment", 32'(tube_segment), 32'(m_tube[7:0]));
    check_eq("irq", 32'(irq), 32'(m_tcon[2] & m_tcon[1]));
    check_eq("uart_txd", 32'(uart_txd), 32'(exp_txd()));
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_bus(0, 0, 4'h0, 32'd0, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    set_bus(1, 0, 4'h0, 32'h0000_0100, 32'd0); #1;
    check_eq("rst_ram", read_data, 32'd0);
    set_bus(1, 0, 4'h0, A_SYST, 32'd0); #1;
    check_eq("rst_systick", read_data, 32'd0);
    check_eq("rst_led", 32'(led), 32'd0);
    check_eq("rst_tube", {20'd0, tube_display, tube_segment}, 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_txd", 32'(uart_txd), 32'd1);
    reset = 1'b0;
    tick();
    check_eq("systick_first", read_data, 32'd1);

    // Byte-lane store
    set_bus(0, 1, 4'hF, 32'h0, 32'hDEAD_BEEF); tick();
    set_bus(0, 1, 4'b0010, 32'h0, 32'h0000_1100); tick();
    set_bus(1, 0, 4'h0, 32'h0, 32'd0); #1;
    check_eq("byte_lane", read_data, 32'hDEAD_11EF);

    // Aliasing above the RAM depth, and the read strobe gate
    set_bus(0, 1, 4'hF, 32'h800, 32'h1234_5678); tick();
    set_bus(1, 0, 4'h0, 32'h0, 32'd0); #1;
    check_eq("alias_word0", read_data, 32'h1234_5678);
    set_bus(0, 0, 4'h0, 32'h0, 32'd0); #1;
    check_eq("read_gated", read_data, 32'd0);

    // Timer reload, interrupt, clear and overflow-vs-clear collision
    set_bus(0, 1, 4'hF, A_TH, 32'hFFFF_FFFD); tick();
    set_bus(0, 1, 4'hF, A_TL, 32'hFFFF_FFFE); tick();
    set_bus(0, 1, 4'hF, A_TCON, 32'd3); tick();
    set_bus(1, 0, 4'h0, A_TL, 32'd0); #1;
    check_eq("tl_count0", read_data, 32'hFFFF_FFFE);
    tick();
    check_eq("tl_count1", read_data, 32'hFFFF_FFFF);
    check_eq("irq_pre", 32'(irq), 32'd0);
    tick();
    check_eq("tl_reload", read_data, 32'hFFFF_FFFD);
    check_eq("irq_set", 32'(irq), 32'd1);
    set_bus(0, 1, 4'hF, A_TCON, 32'd3); tick();
    set_bus(1, 0, 4'h0, A_TCON, 32'd0); #1;
    check_eq("irq_cleared", 32'(irq), 32'd0);
    check_eq("tcon_after_clear", read_data, 32'd3);
    tick();
    set_bus(0, 1, 4'hF, A_TCON, 32'd3); tick();
    check_eq("irq_set_wins", 32'(irq), 32'd1);
    set_bus(0, 1, 4'hF, A_TCON, 32'd0); tick();

    // Tube register
    set_bus(0, 1, 4'h0, A_TUBE, 32'h0000_0A3F); tick();
    set_bus(1, 0, 4'h0, A_TUBE, 32'd0); #1;
    check_eq("tube_disp", 32'(tube_display), 32'hA);
    check_eq("tube_seg", 32'(tube_segment), 32'h3F);
    check_eq("tube_read", read_data, 32'h0000_0A3F);

`ifdef UART_TX_EN
    // One 0x55 frame, with a second store mid-frame that must be dropped
    set_bus(0, 1, 4'hF, A_UTXD, 32'h55); tick();
    for (int i = 0; i < 10 * BAUD; i++) begin
      int k = i / BAUD;
      logic [7:0] byte55 = 8'h55;
      logic e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : byte55[k-1];
      if (i == 5) set_bus(0, 1, 4'hF, A_UTXD, 32'hAA);
      else set_bus(1, 0, 4'h0, A_UCON, 32'd0);
      #1;
      check_eq("frame_txd", 32'(uart_txd), 32'(e));
      if (i != 5) check_eq("frame_busy", read_data, 32'd1);
      tick();
    end
    set_bus(1, 0, 4'h0, A_UCON, 32'd0); #1;
    check_eq("frame_done", read_data, 32'd2);
    set_bus(1, 0, 4'h0, A_UTXD, 32'd0); #1;
    check_eq("frame_byte", read_data, 32'h55);
    set_bus(0, 1, 4'hF, A_UCON, 32'd0); tick();
    set_bus(1, 0, 4'h0, A_UCON, 32'd0); #1;
    check_eq("done_cleared", read_data, 32'd0);
`else
    set_bus(0, 1, 4'hF, A_UTXD, 32'h55); tick();
    set_bus(1, 0, 4'h0, A_UTXD, 32'd0); #1;
    check_eq("uart_absent_rd", read_data, 32'd0);
    check_eq("uart_absent_txd", 32'(uart_txd), 32'd1);
`endif

    // Random traffic over RAM, registers and unmapped space
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, wd;
      int r = $urandom_range(0, 99);
      if (r < 45) a = ($urandom_range(0, 63) << 2) | ($urandom_range(0, 3) << 11) | 32'($urandom_range(0, 3));
      else a = mmio_list[$urandom_range(0, 10)];
      wd = $urandom;
      if (a == A_TL) wd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if (a == A_TCON || a == A_UCON) wd = 32'($urandom_range(0, 7));
      set_bus($urandom_range(0, 4) != 0, $urandom_range(0, 1) != 0, 4'($urandom_range(0, 15)), a, wd);
      tick();
    end

    // Asynchronous reset mid-count and mid-frame
    set_bus(0, 1, 4'hF, A_LED, 32'hA5); tick();
    set_bus(0, 1, 4'hF, A_TCON, 32'd3); tick();
    set_bus(0, 1, 4'hF, A_UTXD, 32'h00); tick();
    set_bus(1, 0, 4'h0, A_SYST, 32'd0);
    repeat (6) tick();
`ifdef UART_TX_EN
    check_eq("txd_midframe", 32'(uart_txd), 32'd0);
`endif
    check_eq("led_before_rst", 32'(led), 32'hA5);
    #1 reset = 1'b1;
    #1;
    model_reset();
    check_eq("arst_led", 32'(led), 32'd0);
    check_eq("arst_irq", 32'(irq), 32'd0);
    check_eq("arst_txd", 32'(uart_txd), 32'd1);
    check_eq("arst_systick", read_data, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("systick_restart", read_data, 32'd0);
    tick();
    check_eq("systick_after", read_data, 32'd1);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
